// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the digit counter; a single-digit build still needs one bit.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from chained one-bit full-adder cells.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    // c_msb is the carry into the top cell, needed for signed overflow.
    always_comb begin
        logic       cy;
        logic [1:0] fa;
        cy    = cin;
        c_msb = cin;
        s     = '0;
        fa    = '0;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb = cy;
            fa    = full_add(a[i], b[i], cy);
            s[i]  = fa[0];
            cy    = fa[1];
        end
        cout = cy;
    end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | one digit added per cycle, NDIG cycles
//   DONE  | result held on Sum/Cout/Ovf until out_ready
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, psum, psum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] d_s;
    logic             d_cout, d_cmsb;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .cin   (carry),
        .s     (d_s),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    // New digits enter from the MSB side so the word is aligned after NDIG shifts.
    if (DIGIT == WIDTH) begin : g_psum_single
        assign psum_nxt = d_s;
    end else begin : g_psum_shift
        assign psum_nxt = {d_s, psum[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)    state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == RUN) || (state == DONE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= A;
                        b_sh  <= Sub ? ~B : B;
                        carry <= Sub ? 1'b1 : Cin;
                        psum  <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    psum  <= psum_nxt;
                    carry <= d_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Sum  <= psum_nxt;
                        Cout <= d_cout;
                        Ovf  <= d_cmsb ^ d_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised digit-serial adder/subtractor. It accepts two WIDTH-bit operands over a valid/ready handshake and processes DIGIT bits per clock, LSB first, using a DIGIT-bit ripple cell. It returns Sum, Cout and a signed-overflow flag over a second valid/ready handshake. It is the area-reduced successor to our single-bit combinational adder cell, for datapaths where latency is acceptable.

Parameters:
WIDTH, 8, operand and result width in bits; must be ≥ 1
DIGIT, 1, bits processed per clock; WIDTH % DIGIT must be 0, otherwise elaboration fails via $error
(derived) NDIG = WIDTH/DIGIT, number of RUN cycles per operation

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  operands presented
in_ready  out  1  block can accept operands (high only in IDLE)
A  in  WIDTH  operand A
B  in  WIDTH  operand B
Cin  in  1  carry-in, used when Sub=0
Sub  in  1  1 = compute A − B (A + ~B + 1); Cin ignored
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
Sum  out  WIDTH  result, registered
Cout  out  1  carry out of MSB (for Sub=1: 1 = no borrow)
Ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB
busy  out  1  high in RUN or DONE

Behaviour:
- Reset:
  - Clock and reset: single clock; reset is asynchronous and active-low.
  - Assertion of rst_n forces state IDLE immediately.
  - Reset values: Sum=0, Cout=0, Ovf=0, out_valid=0, busy=0; internal counter, carry and shift registers cleared.
  - in_ready = (state==IDLE), so it reads 1 during reset.
  - An operation in progress is discarded with no partial output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready edge: latch A into the shift register, and B or ~B (per Sub) into the shift register.
  - Carry reg = Sub ? 1 : Cin; cnt=0; go to RUN.
- RUN:
  - Each cycle, the digit_adder adds the low DIGIT bits of both shift regs plus the carry reg.
  - Result digit is shifted into the partial-sum reg from the MSB side; operand regs shift right by DIGIT; carry reg is updated.
  - cnt increments. On the cycle where cnt==NDIG-1, go to DONE.
  - On that same edge, load Sum (the complete partial sum), Cout (final carry) and Ovf (carry-into-MSB XOR final carry).
- DONE:
  - out_valid=1.
  - Sum, Cout and Ovf are held stable until out_valid && out_ready; on that edge go to IDLE and drop out_valid.
- Outputs change only on the edge entering DONE, or on reset. Partial values never appear on Sum.
- Latency: out_valid rises exactly NDIG cycles after the input-handshake edge.
- Throughput: operations do not overlap. Minimum issue period is NDIG+2 cycles (accept, NDIG RUN, one DONE cycle, back to IDLE).
- in_valid while in_ready=0 is ignored; the operands need not be held.
- A, B, Cin and Sub are sampled only on the accepting edge.
- Boundary DIGIT==WIDTH: one RUN cycle, latency 1.
- Boundary WIDTH==1: Ovf = carry-in XOR Cout of the single bit.
- All arithmetic is modulo 2^WIDTH. Cout is the WIDTH+1 bit.

Decomposition:
- Package adder_pkg: state enum typedef (IDLE, RUN, DONE) and a function computing the counter width, $clog2(NDIG) with minimum 1.
- Sub-module digit_adder #(DIGIT): purely combinational DIGIT-bit ripple adder built from chained one-bit full-adder cells.
  - Inputs: a, b, cin. Outputs: s, cout, and c_msb (the carry into its top bit, needed for Ovf).
- Counter, shift registers and FSM live in serial_adder.

Test Plan:
1. Reset: hold rst_n=0 with in_valid=1 → out_valid=0, Sum=0, Cout=0, Ovf=0, busy=0, in_ready=1. Release, idle 3 cycles → no operation starts without an accept edge after reset.
2. Add, WIDTH=8 DIGIT=1: A=8'h5A, B=8'h3C, Cin=1, Sub=0 → out_valid exactly 8 cycles after accept; Sum=8'h97, Cout=0, Ovf=1.
3. Wrap-around: A=8'hFF, B=8'h01, Cin=0 → Sum=8'h00, Cout=1, Ovf=0. Also A=8'h7F, B=8'h01 → Sum=8'h80, Cout=0, Ovf=1.
4. Subtract: A=8'h10, B=8'h20, Sub=1, Cin=1 (ignored) → Sum=8'hF0, Cout=0, Ovf=0. A=8'h20, B=8'h10, Sub=1 → Sum=8'h10, Cout=1.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving new in_valid → Sum stays stable, in_ready=0, new op ignored. Then out_ready=1 → IDLE next cycle; the following op is accepted and gives the correct result; issue period = 10 cycles.
6. Reset mid-op and variant: drop rst_n in the 4th RUN cycle → out_valid and busy go 0 immediately; the next op after release gives a correct result. Rebuild with WIDTH=16, DIGIT=4: A=16'hFFFF, B=16'h0001 → latency 4, Sum=16'h0000, Cout=1, Ovf=0.
